// File: rtl/cu_pkg.sv
// Shared encodings for the microprogrammed control unit: ROM next-state actions,
// condition selects and next-state mux selects.
package cu_pkg;

  typedef enum logic [2:0] {
    N_ENC        = 3'b000,
    N_ZERO       = 3'b001,
    N_CR         = 3'b010,
    N_INC        = 3'b011,
    N_C_ENC      = 3'b100,
    N_C_CR_INC   = 3'b101,
    N_C_INC_HOLD = 3'b110,
    N_C_CR_HOLD  = 3'b111
  } action_e;

  typedef enum logic [1:0] {
    S_MOC  = 2'b00,
    S_COND = 2'b01,
    S_IBIT = 2'b10,
    S_ONE  = 2'b11
  } csel_e;

  typedef enum logic [1:0] {
    MSEL_ENC  = 2'b00,
    MSEL_ZERO = 2'b01,
    MSEL_CR   = 2'b10,
    MSEL_INC  = 2'b11
  } msel_e;

endpackage

// File: rtl/microseq_cond_sel.sv
// Condition tester front end: picks one of four condition sources by s and
// applies the ROM's invert bit.
module microseq_cond_sel
  import cu_pkg::*;
(
  input  logic [1:0] s,
  input  logic       moc,
  input  logic       cond,
  input  logic       ibit,
  input  logic       inv,
  output logic       c_eff
);

  logic c_raw;

  always_comb begin
    c_raw = 1'b1;
    case (s)
      S_MOC:  c_raw = moc;
      S_COND: c_raw = cond;
      S_IBIT: c_raw = ibit;
      S_ONE:  c_raw = 1'b1;
      default: c_raw = 1'b1;
    endcase
  end

  assign c_eff = c_raw ^ inv;

endmodule

// File: rtl/microseq_next_state.sv
// Next-state address sequencer feeding the control-store ROM address.
// Optional hold watchdog enabled by defining MICROSEQ_TIMEOUT_EN.
module microseq_next_state
  import cu_pkg::*;
#(
  parameter int              SW          = 8,
  parameter int              CRW         = 6,
  parameter logic [SW-1:0]   RESET_STATE = '0,
  parameter int              TIMEOUT     = 16,
  parameter logic [SW-1:0]   ABORT_STATE = '0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [SW-1:0]  enc_state,
  input  logic [CRW-1:0] cr,
  input  logic [2:0]     n,
  input  logic           inv,
  input  logic [1:0]     s,
  input  logic           moc,
  input  logic           cond,
  input  logic           ibit,
  output logic [SW-1:0]  state,
  output logic [1:0]     m_sel,
  output logic           hold,
  output logic           timeout
);

  logic          c_eff;
  logic [1:0]    sel;
  logic          is_hold;
  logic          expire;
  logic [SW-1:0] cr_ext;
  logic [SW-1:0] inc_state;
  logic [SW-1:0] mux_out;
  logic [SW-1:0] next_d;

  microseq_cond_sel u_cond_sel (
    .s     (s),
    .moc   (moc),
    .cond  (cond),
    .ibit  (ibit),
    .inv   (inv),
    .c_eff (c_eff)
  );

  assign cr_ext    = {{(SW-CRW){1'b0}}, cr};
  assign inc_state = state + SW'(1);

  // Wait actions still report the mux leg they would take, but keep the register.
  always_comb begin
    sel     = MSEL_INC;
    is_hold = 1'b0;
    case (n)
      N_ENC:        sel = MSEL_ENC;
      N_ZERO:       sel = MSEL_ZERO;
      N_CR:         sel = MSEL_CR;
      N_INC:        sel = MSEL_INC;
      N_C_ENC:      sel = c_eff ? MSEL_ENC : MSEL_ZERO;
      N_C_CR_INC:   sel = c_eff ? MSEL_CR  : MSEL_INC;
      N_C_INC_HOLD: begin sel = MSEL_INC; is_hold = ~c_eff; end
      N_C_CR_HOLD:  begin sel = MSEL_CR;  is_hold = ~c_eff; end
      default:      sel = MSEL_INC;
    endcase
  end

  always_comb begin
    mux_out = inc_state;
    case (sel)
      MSEL_ENC:  mux_out = enc_state;
      MSEL_ZERO: mux_out = RESET_STATE;
      MSEL_CR:   mux_out = cr_ext;
      MSEL_INC:  mux_out = inc_state;
      default:   mux_out = inc_state;
    endcase
    next_d = is_hold ? state : mux_out;
  end

`ifdef MICROSEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] hold_cnt;

  assign expire = is_hold && (hold_cnt >= CW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= expire;
      if (!is_hold || expire)
        hold_cnt <= '0;
      else if (hold_cnt != '1)
        hold_cnt <= hold_cnt + CW'(1);
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT;
  assign expire             = 1'b0;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RESET_STATE;
      m_sel <= MSEL_ZERO;
      hold  <= 1'b0;
    end else begin
      state <= expire ? ABORT_STATE : next_d;
      m_sel <= sel;
      hold  <= is_hold && !expire;
    end
  end

endmodule

// File: tb/tb_microseq_next_state.sv
// Scoreboard bench for microseq_next_state; timeout checks follow MICROSEQ_TIMEOUT_EN.
module tb_microseq_next_state;

  localparam logic [7:0] ABORT = 8'h1F;
  localparam int         TMO   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] enc_state;
  logic [5:0] cr;
  logic [2:0] n;
  logic       inv;
  logic [1:0] s;
  logic       moc;
  logic       cond;
  logic       ibit;
  logic [7:0] state;
  logic [1:0] m_sel;
  logic       hold;
  logic       timeout;

  typedef struct packed {
    logic [7:0] st;
    logic [1:0] ms;
    logic       hd;
    logic       to;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] mstate;
  int         mcnt;
  int         tests = 0;
  int         fails = 0;

  microseq_next_state #(
    .SW(8), .CRW(6), .RESET_STATE(8'h00), .TIMEOUT(TMO), .ABORT_STATE(ABORT)
  ) dut (
    .clk(clk), .reset(reset), .enc_state(enc_state), .cr(cr), .n(n),
    .inv(inv), .s(s), .moc(moc), .cond(cond), .ibit(ibit),
    .state(state), .m_sel(m_sel), .hold(hold), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour: compute the expected registered result from the inputs
  // currently driven, queue it, then compare once the edge has happened.
  task automatic applyStimulus(input string tag, input logic rst);
    exp_t       e;
    exp_t       got;
    logic       c;
    logic       cp;
    logic [7:0] plus1;
    logic [7:0] crx;
    c     = (s == 2'd0) ? moc : (s == 2'd1) ? cond : (s == 2'd2) ? ibit : 1'b1;
    cp    = c ^ inv;
    plus1 = mstate + 8'd1;
    crx   = {2'b00, cr};
    e     = '0;
    if (rst) begin
      e.st = 8'h00; e.ms = 2'b01; mcnt = 0;
    end else begin
      case (n)
        3'd0: begin e.st = enc_state; e.ms = 2'b00; end
        3'd1: begin e.st = 8'h00;     e.ms = 2'b01; end
        3'd2: begin e.st = crx;       e.ms = 2'b10; end
        3'd3: begin e.st = plus1;     e.ms = 2'b11; end
        3'd4: begin e.st = cp ? enc_state : 8'h00; e.ms = cp ? 2'b00 : 2'b01; end
        3'd5: begin e.st = cp ? crx : plus1;       e.ms = cp ? 2'b10 : 2'b11; end
        3'd6: begin e.st = cp ? plus1 : mstate;    e.ms = 2'b11; e.hd = ~cp; end
        default: begin e.st = cp ? crx : mstate;   e.ms = 2'b10; e.hd = ~cp; end
      endcase
`ifdef MICROSEQ_TIMEOUT_EN
      if (e.hd && mcnt >= TMO) begin
        e.st = ABORT; e.hd = 1'b0; e.to = 1'b1; mcnt = 0;
      end else if (e.hd) begin
        mcnt++;
      end else begin
        mcnt = 0;
      end
`endif
    end
    mstate = e.st;
    reset  = rst;
    expq.push_back(e);
    @(posedge clk);
    #1;
    got = expq.pop_front();
    checkOutput({tag, ".state"},   state,   got.st);
    checkOutput({tag, ".m_sel"},   m_sel,   got.ms);
    checkOutput({tag, ".hold"},    hold,    got.hd);
    checkOutput({tag, ".timeout"}, timeout, got.to);
  endtask

  task automatic setInputs(input logic [2:0] an, input logic [1:0] as, input logic ainv,
                           input logic amoc, input logic acond, input logic aibit,
                           input logic [7:0] aenc, input logic [5:0] acr);
    n = an; s = as; inv = ainv; moc = amoc; cond = acond; ibit = aibit;
    enc_state = aenc; cr = acr;
  endtask

  task automatic loadState(input logic [7:0] v);
    setInputs(3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, v, 6'h00);
    applyStimulus("load", 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mstate = 8'h00;
    mcnt   = 0;
    reset  = 1'b1;
    setInputs(3'b010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 6'h2A);
    applyStimulus("reset0", 1'b1);
    applyStimulus("reset1", 1'b1);
    checkOutput("reset_state_lit", state, 8'h00);
    checkOutput("reset_msel_lit", m_sel, 2'b01);

    // fetch path
    loadState(8'h01);
    setInputs(3'b011, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 6'h00);
    applyStimulus("inc_a", 1'b0);
    applyStimulus("inc_b", 1'b0);
    checkOutput("inc_lit", state, 8'h03);
    setInputs(3'b100, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0A, 6'h00);
    applyStimulus("decode", 1'b0);
    checkOutput("decode_lit", state, 8'h0A);
    setInputs(3'b100, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0A, 6'h00);
    applyStimulus("decode_false", 1'b0);

    // memory wait, then moc rises on the wait action
    loadState(8'h02);
    setInputs(3'b110, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 6'h00);
    for (int i = 0; i < 3; i++) applyStimulus("moc_wait", 1'b0);
    checkOutput("moc_wait_lit", {state, hold}, {8'h02, 1'b1});
    moc = 1'b1;
    applyStimulus("moc_done", 1'b0);
    checkOutput("moc_done_lit", {state, hold}, {8'h03, 1'b0});

    // inverted ibit branch
    loadState(8'h0B);
    setInputs(3'b101, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 6'h0A);
    applyStimulus("inv_ibit1", 1'b0);
    checkOutput("inv_ibit1_lit", state, 8'h0C);
    loadState(8'h0B);
    setInputs(3'b101, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'h0A);
    applyStimulus("inv_ibit0", 1'b0);
    checkOutput("inv_ibit0_lit", state, 8'h0A);

    // wrap and zero-extension
    loadState(8'hFF);
    setInputs(3'b011, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 6'h00);
    applyStimulus("wrap", 1'b0);
    checkOutput("wrap_lit", state, 8'h00);
    setInputs(3'b010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 6'h3F);
    applyStimulus("cr_zext", 1'b0);
    checkOutput("cr_zext_lit", state, 8'h3F);

    // constant-one condition on the CR/hold action
    setInputs(3'b111, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'h15);
    applyStimulus("one_inv_hold", 1'b0);
    inv = 1'b0;
    applyStimulus("one_cr", 1'b0);

    // long hold: watchdog aborts only when enabled
    loadState(8'h02);
    setInputs(3'b110, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 6'h00);
    for (int i = 0; i < TMO; i++) applyStimulus("long_hold", 1'b0);
    applyStimulus("hold_expire", 1'b0);
`ifdef MICROSEQ_TIMEOUT_EN
    checkOutput("abort_lit", {state, timeout}, {ABORT, 1'b1});
`else
    checkOutput("no_abort_lit", {state, timeout}, {8'h02, 1'b0});
`endif
    applyStimulus("after_expire", 1'b0);

    // reset in the middle of a wait clears the hold count
    loadState(8'h02);
    for (int i = 0; i < 2; i++) begin
      setInputs(3'b110, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 6'h00);
      applyStimulus("pre_reset_hold", 1'b0);
    end
    applyStimulus("mid_wait_reset", 1'b1);
    checkOutput("mid_wait_reset_lit", {state, hold, timeout}, {8'h00, 1'b0, 1'b0});
    for (int i = 0; i < TMO + 2; i++) applyStimulus("post_reset_hold", 1'b0);

    // reset dominates an entry action
    setInputs(3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 6'h00);
    applyStimulus("reset_dominates", 1'b1);

    // random mix
    for (int i = 0; i < 200; i++) begin
      setInputs(3'($urandom_range(7)), 2'($urandom_range(3)), 1'($urandom_range(1)),
                1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                8'($urandom_range(255)), 6'($urandom_range(63)));
      applyStimulus("random", ($urandom_range(31) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
